// File: rtl/mem_arb.sv
// Two-port arbiter for the single-port data memory: CPU has fixed priority, io is forced through after STARVE_MAX denied cycles.
// Optional debug counters (conflict_cnt, force_cnt) are compiled in with `define MEM_ARB_STATS_EN.
module mem_arb #(
    parameter int AW         = 8,
    parameter int DW         = 26,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          io_req,
    input  logic          io_we,
    input  logic [AW-1:0] io_addr,
    input  logic [DW-1:0] io_wdata,
    output logic          io_gnt,
    output logic          io_rvalid,
    output logic [DW-1:0] io_rdata,
`ifdef MEM_ARB_STATS_EN
    output logic [15:0]   conflict_cnt,
    output logic [7:0]    force_cnt,
`endif
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;
    logic       force_io;
    logic       rd_owner_c;
    logic       rd_owner_i;

    assign force_io  = (starve_cnt >= SMAX);
    assign io_gnt    = io_req & (~cpu_req | force_io);
    assign cpu_gnt   = cpu_req & ~io_gnt;
    assign cpu_stall = cpu_req & ~cpu_gnt;

    // Idle cycles present the CPU bus so the memory inputs stay deterministic
    assign mem_addr  = io_gnt ? io_addr : cpu_addr;
    assign mem_wdata = io_gnt ? io_wdata : cpu_wdata;
    assign mem_we    = ~rst & ((cpu_gnt & cpu_we) | (io_gnt & io_we));

    // A reset landing on the return cycle kills the pending rvalid
    assign cpu_rvalid = rd_owner_c & ~rst;
    assign io_rvalid  = rd_owner_i & ~rst;
    assign cpu_rdata  = mem_rdata;
    assign io_rdata   = mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= 4'd0;
            rd_owner_c <= 1'b0;
            rd_owner_i <= 1'b0;
        end else begin
            rd_owner_c <= cpu_gnt & ~cpu_we;
            rd_owner_i <= io_gnt & ~io_we;
            if (~io_req | io_gnt)
                starve_cnt <= 4'd0;
            else if (starve_cnt != 4'hF)
                starve_cnt <= starve_cnt + 4'd1;
        end
    end

`ifdef MEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= 16'd0;
            force_cnt    <= 8'd0;
        end else begin
            if (cpu_req & io_req & (conflict_cnt != 16'hFFFF))
                conflict_cnt <= conflict_cnt + 16'd1;
            if (io_gnt & force_io & (force_cnt != 8'hFF))
                force_cnt <= force_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: vector table of per-cycle grants plus a read-data scoreboard.
// Build with +define+MEM_ARB_STATS_EN to also check the debug counters.
module tb_mem_arb;

    logic        clk;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [7:0]  cpu_addr;
    logic [25:0] cpu_wdata;
    logic        cpu_gnt, cpu_stall, cpu_rvalid;
    logic [25:0] cpu_rdata;
    logic        io_req, io_we;
    logic [7:0]  io_addr;
    logic [25:0] io_wdata;
    logic        io_gnt, io_rvalid;
    logic [25:0] io_rdata;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [25:0] mem_wdata;
    logic [25:0] mem_rdata;
`ifdef MEM_ARB_STATS_EN
    logic [15:0] conflict_cnt;
    logic [7:0]  force_cnt;
`endif

    mem_arb #(.AW(8), .DW(26), .STARVE_MAX(3)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .io_req(io_req), .io_we(io_we),
        .io_addr(io_addr), .io_wdata(io_wdata),
        .io_gnt(io_gnt), .io_rvalid(io_rvalid), .io_rdata(io_rdata),
`ifdef MEM_ARB_STATS_EN
        .conflict_cnt(conflict_cnt), .force_cnt(force_cnt),
`endif
        .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered single-port memory
    logic [25:0] mem [256];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    typedef struct {
        logic        cr, cw;
        logic [7:0]  ca;
        logic [25:0] cd;
        logic        ir, iw;
        logic [7:0]  ia;
        logic [25:0] id;
        logic        ecg, eig, ewe;
    } vec_t;

    vec_t        tv [$];
    logic [25:0] sh [256];
    logic [25:0] cq [$];
    logic [25:0] iq [$];
    logic        exp_crv, exp_irv;
    int          total, bad;

    function automatic vec_t mk(
        logic cr, logic cw, logic [7:0] ca, logic [25:0] cd,
        logic ir, logic iw, logic [7:0] ia, logic [25:0] id,
        logic ecg, logic eig, logic ewe);
        vec_t v;
        v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
        v.ir = ir; v.iw = iw; v.ia = ia; v.id = id;
        v.ecg = ecg; v.eig = eig; v.ewe = ewe;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_rv();
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(exp_crv));
        chk("io_rvalid", 32'(io_rvalid), 32'(exp_irv));
        if (cpu_rvalid === 1'b1) begin
            if (cq.size() == 0) chk("cpu_rd_unexpected", 32'd1, 32'd0);
            else chk("cpu_rdata", 32'(cpu_rdata), 32'(cq.pop_front()));
        end
        if (io_rvalid === 1'b1) begin
            if (iq.size() == 0) chk("io_rd_unexpected", 32'd1, 32'd0);
            else chk("io_rdata", 32'(io_rdata), 32'(iq.pop_front()));
        end
    endtask

    task automatic step(vec_t v);
        @(posedge clk);
        #1;
        cpu_req = v.cr; cpu_we = v.cw; cpu_addr = v.ca; cpu_wdata = v.cd;
        io_req = v.ir; io_we = v.iw; io_addr = v.ia; io_wdata = v.id;
        #3;
        chk_rv();
        chk("cpu_gnt", 32'(cpu_gnt), 32'(v.ecg));
        chk("io_gnt", 32'(io_gnt), 32'(v.eig));
        chk("cpu_stall", 32'(cpu_stall), 32'(v.cr & ~v.ecg));
        chk("mem_we", 32'(mem_we), 32'(v.ewe));
        if (v.ecg) chk("mem_addr_c", 32'(mem_addr), 32'(v.ca));
        if (v.eig) chk("mem_addr_i", 32'(mem_addr), 32'(v.ia));
        if (v.ewe) chk("mem_wdata", 32'(mem_wdata), 32'(v.ecg ? v.cd : v.id));
        exp_crv = v.ecg & ~v.cw;
        exp_irv = v.eig & ~v.iw;
        if (exp_crv) cq.push_back(sh[v.ca]);
        if (exp_irv) iq.push_back(sh[v.ia]);
        if (v.ewe) begin
            if (v.ecg) sh[v.ca] = v.cd;
            else sh[v.ia] = v.id;
        end
    endtask

    localparam logic [25:0] CD = 26'h0055AA;

    initial begin
        total = 0; bad = 0;
        exp_crv = 1'b0; exp_irv = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 26'd0;
            sh[i] = 26'd0;
        end
        mem[8'h20] = 26'h1234;
        sh[8'h20] = 26'h1234;

        // row: cr cw ca cd | ir iw ia id | cgnt ignt we
        tv.push_back(mk(1, 1, 8'h10, 26'h0ABCDE, 0, 0, 8'h00, 0, 1, 0, 1));
        tv.push_back(mk(1, 0, 8'h10, 0, 0, 0, 8'h00, 0, 1, 0, 0));
        tv.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0));
        for (int i = 0; i < 8; i++) begin
            if (i == 3 || i == 7)
                tv.push_back(mk(1, 1, 8'h21, CD, 1, 0, 8'h20, 0, 0, 1, 0));
            else
                tv.push_back(mk(1, 1, 8'h21, CD, 1, 0, 8'h20, 0, 1, 0, 1));
        end
        tv.push_back(mk(1, 0, 8'h21, 0, 0, 0, 8'h00, 0, 1, 0, 0));
        tv.push_back(mk(0, 0, 8'h00, 0, 1, 1, 8'h22, 26'h3, 0, 1, 1));
        tv.push_back(mk(0, 0, 8'h00, 0, 1, 0, 8'h22, 0, 0, 1, 0));
        tv.push_back(mk(1, 0, 8'h10, 0, 1, 1, 8'h30, 26'h777, 1, 0, 0));
        tv.push_back(mk(1, 0, 8'h10, 0, 0, 0, 8'h00, 0, 1, 0, 0));
        tv.push_back(mk(1, 0, 8'h10, 0, 1, 0, 8'h20, 0, 1, 0, 0));
        tv.push_back(mk(1, 0, 8'h10, 0, 1, 0, 8'h20, 0, 1, 0, 0));
        tv.push_back(mk(1, 0, 8'h10, 0, 1, 0, 8'h20, 0, 1, 0, 0));
        tv.push_back(mk(1, 0, 8'h10, 0, 1, 0, 8'h20, 0, 0, 1, 0));
        tv.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0));

        // Reset with both requesters asking to write
        rst = 1'b1;
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h40; cpu_wdata = 26'h111;
        io_req = 1; io_we = 1; io_addr = 8'h41; io_wdata = 26'h222;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #4;
            chk("rst_mem_we", 32'(mem_we), 32'd0);
            chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
            chk("rst_io_rvalid", 32'(io_rvalid), 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0; cpu_req = 0; io_req = 0;
        #3;
        chk("rst_starve_cnt", 32'(dut.starve_cnt), 32'd0);
        chk("rst_rvalid_after", 32'(cpu_rvalid | io_rvalid), 32'd0);
`ifdef MEM_ARB_STATS_EN
        chk("rst_conflict_cnt", 32'(conflict_cnt), 32'd0);
        chk("rst_force_cnt", 32'(force_cnt), 32'd0);
`endif

        for (int i = 0; i < tv.size(); i++) step(tv[i]);
        chk("mem_21", 32'(mem[8'h21]), 32'(CD));

        // io read granted, then reset lands on its return cycle
        step(mk(0, 0, 8'h00, 0, 1, 0, 8'h20, 0, 0, 1, 0));
        @(posedge clk);
        #1;
        rst = 1'b1; io_req = 0;
        #3;
        chk("rst_mid_io_rvalid", 32'(io_rvalid), 32'd0);
        iq.delete();
        exp_irv = 1'b0;
        exp_crv = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #3;
        chk("post_rst_io_rvalid", 32'(io_rvalid), 32'd0);

        // 10 contention cycles from a clean counter
        for (int i = 0; i < 10; i++) begin
            if (i == 3 || i == 7)
                step(mk(1, 0, 8'h10, 0, 1, 0, 8'h20, 0, 0, 1, 0));
            else
                step(mk(1, 0, 8'h10, 0, 1, 0, 8'h20, 0, 1, 0, 0));
        end
        step(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0));
`ifdef MEM_ARB_STATS_EN
        chk("conflict_cnt", 32'(conflict_cnt), 32'd10);
        chk("force_cnt", 32'(force_cnt), 32'd2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #3;
        chk("clr_conflict_cnt", 32'(conflict_cnt), 32'd0);
        chk("clr_force_cnt", 32'(force_cnt), 32'd0);
`endif
        step(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0));
        chk("cq_drained", 32'(cq.size()), 32'd0);
        chk("iq_drained", 32'(iq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
